// File: rtl/vhex_pkg.sv
// vhex_pkg: definitions shared by the vhex dump writer and the vhex ROM loader.
//   vhex_state_t : writer FSM state encoding (also used for the debug output)
//   CH_AT, CH_NL : ASCII '@' and newline
//   nib2ascii()  : 4-bit nibble to lowercase ASCII hex digit
package vhex_pkg;

    typedef enum logic [3:0] {
        IDLE,
        READ,
        WAIT,
        ADDR_AT,
        ADDR_HEX,
        ADDR_NL,
        DATA_HEX,
        DATA_NL,
        NEXT,
        DONE
    } vhex_state_t;

    localparam logic [7:0] CH_AT = 8'h40;
    localparam logic [7:0] CH_NL = 8'h0a;

    // 0-9 -> '0'-'9', a-f -> 'a'-'f' (0x61 - 10 = 0x57)
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/vhex_hex_serializer.sv
// vhex_hex_serializer: shifts a loaded value out as ASCII hex digits, MSB nibble
// first, under a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture load_value / load_last_idx and start emitting
//   load_value [W]    : value, left-aligned (first digit in bits W-1..W-4)
//   load_last_idx     : number of digits minus one
//   ready             : consumer accepts the current digit
//   valid, data[8]    : current ASCII digit
//   last              : current digit is the final one
// Handshake: a digit transfers on a cycle where valid && ready; data holds
// steady while valid is high and ready is low.
module vhex_hex_serializer
    import vhex_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_value,
    input  logic [CNT_W-1:0] load_last_idx,
    input  logic             ready,
    output logic             valid,
    output logic [7:0]       data,
    output logic             last
);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= load_value;
            cnt    <= load_last_idx;
            active <= 1'b1;
        end else if (active && ready) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                shreg <= shreg << 4;
                cnt   <= cnt - 1'b1;
            end
        end
    end

    assign valid = active;
    assign data  = nib2ascii(shreg[W-1 -: 4]);
    assign last  = active && (cnt == '0);

endmodule

// File: rtl/vhex_dump_writer.sv
// vhex_dump_writer: walks a word-addressed memory through a synchronous read
// port and emits a vhex text stream ("@addr\n" markers, one hex word per line;
// zero words are skipped and reappear as address gaps).
//   clock, reset     : clock, asynchronous active-low reset
//   io_start         : begin a dump (sampled only in IDLE)
//   io_busy, io_done : dump in progress / one-cycle completion pulse
//   io_rd_en, io_rd_addr, io_rd_data : memory read port, data 1 cycle after en
//   io_tx_valid, io_tx_ready, io_tx_data : byte stream to the text sink
//   io_dbg_state     : current FSM state
// Handshake: a byte transfers on a cycle where io_tx_valid && io_tx_ready;
// while valid is high and ready is low, valid and data hold steady.
module vhex_dump_writer
    import vhex_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_rd_en,
    output logic [ADDR_W-1:0] io_rd_addr,
    input  logic [DATA_W-1:0] io_rd_data,
    output logic              io_tx_valid,
    input  logic              io_tx_ready,
    output logic [7:0]        io_tx_data,
    output vhex_state_t       io_dbg_state
);

    localparam int DATA_DIGITS = DATA_W / 4;
    localparam int ADDR_DIGITS = (ADDR_W + 3) / 4;
    // One serializer serves both fields, so its counter is sized for the wider.
    localparam int CNT_W = (DATA_DIGITS > 1) ? $clog2(DATA_DIGITS) : 1;
    // Address is left-aligned in the serializer so its first digit is on top.
    localparam int ADDR_SHIFT = DATA_W - ADDR_DIGITS * 4;
    localparam logic [CNT_W-1:0] DATA_IDX = CNT_W'(DATA_DIGITS - 1);
    localparam logic [CNT_W-1:0] ADDR_IDX = CNT_W'(ADDR_DIGITS - 1);

    vhex_state_t       state, state_n;
    logic [ADDR_W-1:0] addr, last_addr;
    logic              last_valid;
    logic [DATA_W-1:0] word;

    logic              ser_load, ser_ready, ser_valid, ser_last;
    logic [DATA_W-1:0] ser_value;
    logic [CNT_W-1:0]  ser_last_idx;
    logic [7:0]        ser_data;

    vhex_hex_serializer #(.W(DATA_W), .CNT_W(CNT_W)) u_ser (
        .clk           (clock),
        .rst_n         (reset),
        .load          (ser_load),
        .load_value    (ser_value),
        .load_last_idx (ser_last_idx),
        .ready         (ser_ready),
        .valid         (ser_valid),
        .data          (ser_data),
        .last          (ser_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            last_addr  <= '0;
            last_valid <= 1'b0;
            word       <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (io_start) begin
                    addr       <= '0;
                    last_valid <= 1'b0;
                end
                WAIT: begin
                    word <= io_rd_data;
                    if (io_rd_data == '0) last_valid <= 1'b0;
                end
                DATA_NL: if (io_tx_ready) begin
                    last_addr  <= addr;
                    last_valid <= 1'b1;
                end
                NEXT: if (!(&addr)) addr <= addr + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n      = state;
        ser_load     = 1'b0;
        ser_value    = '0;
        ser_last_idx = '0;
        ser_ready    = 1'b0;
        io_done      = 1'b0;
        io_rd_en     = 1'b0;
        io_tx_valid  = 1'b0;
        io_tx_data   = 8'h00;
        case (state)
            IDLE: if (io_start) state_n = READ;
            READ: begin
                io_rd_en = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (io_rd_data == '0) begin
                    state_n = NEXT;
                end else if (!last_valid || addr != last_addr + 1'b1) begin
                    state_n = ADDR_AT;
                end else begin
                    // Contiguous word: no marker, serialize straight from the port.
                    ser_load     = 1'b1;
                    ser_value    = io_rd_data;
                    ser_last_idx = DATA_IDX;
                    state_n      = DATA_HEX;
                end
            end
            ADDR_AT: begin
                io_tx_valid = 1'b1;
                io_tx_data  = CH_AT;
                if (io_tx_ready) begin
                    ser_load     = 1'b1;
                    ser_value    = DATA_W'(addr) << ADDR_SHIFT;
                    ser_last_idx = ADDR_IDX;
                    state_n      = ADDR_HEX;
                end
            end
            ADDR_HEX: begin
                io_tx_valid = ser_valid;
                io_tx_data  = ser_data;
                ser_ready   = io_tx_ready;
                if (ser_last && io_tx_ready) state_n = ADDR_NL;
            end
            ADDR_NL: begin
                io_tx_valid = 1'b1;
                io_tx_data  = CH_NL;
                if (io_tx_ready) begin
                    ser_load     = 1'b1;
                    ser_value    = word;
                    ser_last_idx = DATA_IDX;
                    state_n      = DATA_HEX;
                end
            end
            DATA_HEX: begin
                io_tx_valid = ser_valid;
                io_tx_data  = ser_data;
                ser_ready   = io_tx_ready;
                if (ser_last && io_tx_ready) state_n = DATA_NL;
            end
            DATA_NL: begin
                io_tx_valid = 1'b1;
                io_tx_data  = CH_NL;
                if (io_tx_ready) state_n = NEXT;
            end
            NEXT: state_n = (&addr) ? DONE : READ;
            DONE: begin
                io_done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign io_busy      = (state != IDLE);
    assign io_rd_addr   = addr;
    assign io_dbg_state = state;

endmodule

// File: tb/tb_vhex_dump_writer.sv
module tb_vhex_dump_writer;
    import vhex_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_start = 1'b0;
    logic        io_busy, io_done, io_rd_en;
    logic [6:0]  io_rd_addr;
    logic [31:0] io_rd_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b1;
    logic [7:0]  io_tx_data;
    vhex_state_t io_dbg_state;

    logic [31:0] mem [128];
    logic [31:0] rd_data = '0;

    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];
    bit          prev_hold;
    logic [7:0]  prev_data;
    int          tests = 0;
    int          fails = 0;
    int          rd0;
    int          done_cyc;

    // ---------------- clock / memory model ----------------
    always #5 clock = ~clock;

    always @(posedge clock) if (io_rd_en) rd_data <= mem[io_rd_addr];
    assign io_rd_data = rd_data;

    vhex_dump_writer #(.ADDR_W(7), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_rd_en     (io_rd_en),
        .io_rd_addr   (io_rd_addr),
        .io_rd_data   (io_rd_data),
        .io_tx_valid  (io_tx_valid),
        .io_tx_ready  (io_tx_ready),
        .io_tx_data   (io_tx_data),
        .io_dbg_state (io_dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic clear_mem();
        foreach (mem[k]) mem[k] = '0;
    endtask

    // Called at every negedge while a dump runs: scoreboard + hold checks.
    task automatic monitor_step();
        if (reset && prev_hold)
            check("tx_hold", {io_tx_valid, io_tx_data}, {1'b1, prev_data});
        if (reset && io_tx_valid && io_tx_ready) begin
            rx_q.push_back(io_tx_data);
            if (exp_q.size() == 0) check("tx_extra_byte", {1'b1, io_tx_data}, 9'h0);
            else check("tx_byte", io_tx_data, exp_q.pop_front());
        end
        if (reset && io_rd_en && io_rd_addr == 7'd0) rd0++;
        prev_hold = reset && io_tx_valid && !io_tx_ready;
        prev_data = io_tx_data;
    endtask

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
        return 4'(c - 8'h57);
    endfunction

    // Reload the captured stream into a ROM image and compare against mem.
    function automatic bit loopback_ok();
        logic [31:0] rom [128];
        logic [31:0] w;
        int a, i;
        bit ok;
        foreach (rom[k]) rom[k] = '0;
        a = 0; i = 0;
        while (i < rx_q.size()) begin
            bit is_addr;
            is_addr = (rx_q[i] == 8'h40);
            if (is_addr) i++;
            w = '0;
            while (i < rx_q.size() && rx_q[i] != 8'h0a) begin
                w = (w << 4) | {28'h0, hexval(rx_q[i])};
                i++;
            end
            i++;
            if (is_addr) a = int'(w);
            else begin
                if (a < 128) rom[a] = w;
                a++;
            end
        end
        ok = 1'b1;
        foreach (rom[k]) if (rom[k] !== mem[k]) ok = 1'b0;
        return ok;
    endfunction

    // Driver: start a dump, run until io_done (bounded), return done cycle.
    // Cycle 0 is the cycle in which start is presented to IDLE.
    task automatic run_dump(input bit rnd, input bit poke, output int dcyc);
        int cyc;
        bit seen;
        bit busy_bad;
        cyc = 0; seen = 0; busy_bad = 0; dcyc = -1; rd0 = 0;
        prev_hold = 0;
        rx_q.delete();
        @(posedge clock); #2;
        io_start = 1'b1;
        io_tx_ready = 1'b1;
        while (!seen && cyc < 5000) begin
            @(negedge clock);
            monitor_step();
            if (cyc == 0) check("busy_before_accept", io_busy, 1'b0);
            if (io_done) begin
                seen = 1;
                dcyc = cyc;
                check("busy_at_done", io_busy, 1'b1);
            end else if (cyc >= 1 && !io_busy) begin
                busy_bad = 1;
            end
            @(posedge clock); #2;
            io_start = poke && (cyc == 40 || cyc == 200);
            io_tx_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
            cyc++;
        end
        io_start = 1'b0;
        io_tx_ready = 1'b1;
        check("done_seen", seen, 1'b1);
        check("busy_held", busy_bad, 1'b0);
        @(negedge clock);
        check("done_single_pulse", {io_done, io_busy}, 2'b00);
        check("stream_consumed", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_mem();
        #1;
        check("reset_outputs", {io_busy, io_done, io_rd_en, io_tx_valid, io_rd_addr, io_tx_data}, '0);
        check("reset_state", io_dbg_state, IDLE);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;

        // Two contiguous words at 0.
        mem[0] = 32'h5a5a0000;
        mem[1] = 32'h5a5a0001;
        push_str("@00\n5a5a0000\n5a5a0001\n");
        run_dump(1'b0, 1'b0, done_cyc);
        check("t1_done_cycle", done_cyc, 407);
        check("t1_single_read_addr0", rd0, 1);
        check("t1_loopback", loopback_ok(), 1'b1);

        // Two isolated words, each needs its own marker.
        clear_mem();
        mem[7'h10] = 32'h5a5a0010;
        mem[7'h30] = 32'h5a5a0030;
        push_str("@10\n5a5a0010\n@30\n5a5a0030\n");
        run_dump(1'b0, 1'b0, done_cyc);
        check("t2_done_cycle", done_cyc, 411);
        check("t2_loopback", loopback_ok(), 1'b1);

        // All-zero memory, stray start pulses while busy.
        clear_mem();
        run_dump(1'b0, 1'b1, done_cyc);
        check("t3_done_cycle", done_cyc, 385);
        check("t3_no_bytes", rx_q.size(), 0);
        check("t3_single_read_addr0", rd0, 1);

        // Top address with random backpressure.
        clear_mem();
        mem[7'h7f] = 32'h00000001;
        push_str("@7f\n00000001\n");
        run_dump(1'b1, 1'b0, done_cyc);
        check("t4_no_wrap_read", rd0, 1);
        check("t4_loopback", loopback_ok(), 1'b1);

        // Reset in the middle of word 1's data digits.
        clear_mem();
        mem[0] = 32'h5a5a0000;
        mem[1] = 32'h5a5a0001;
        push_str("@00\n5a5a0000\n5a5a0001\n");
        prev_hold = 0;
        @(posedge clock); #2 io_start = 1'b1;
        @(posedge clock); #2 io_start = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 200 && !(io_dbg_state == DATA_HEX && io_rd_addr == 7'd1)) begin
                @(negedge clock);
                monitor_step();
                n++;
            end
            check("t5_reached_word1", (n < 200), 1'b1);
        end
        @(posedge clock); #2 reset = 1'b0;
        #1;
        check("t5_abort_outputs", {io_busy, io_done, io_rd_en, io_tx_valid, io_rd_addr, io_tx_data}, '0);
        check("t5_abort_state", io_dbg_state, IDLE);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        push_str("@00\n5a5a0000\n5a5a0001\n");
        run_dump(1'b0, 1'b0, done_cyc);
        check("t5_restart_done_cycle", done_cyc, 407);
        check("t5_restart_loopback", loopback_ok(), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vhex_dump_writer.md
# vhex_dump_writer

Memory-dump engine that walks a word-addressed memory through a synchronous read port and emits its contents as an ASCII vhex text stream: `@addr` markers followed by one hex word per line. It is the write-side counterpart of the vhex ROM loader: a stream produced here reloads into an identical ROM image, with all-zero words represented as gaps. It sits between an on-chip memory read port and a byte-wide text sink such as a UART TX FIFO or a debug channel.

## Interface
- `ADDR_W`, 7: memory address width; `DEPTH = 2**ADDR_W` words.
- `DATA_W`, 32: word width; must be a multiple of 4.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `io_busy`  out  1  high from the cycle after start is accepted until DONE inclusive.
- `io_done`  out  1  one-cycle pulse when the dump completes.
- `io_rd_en`  out  1  memory read strobe.
- `io_rd_addr`  out  ADDR_W  memory read address.
- `io_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `io_rd_en`.
- `io_tx_valid`  out  1  byte available.
- `io_tx_ready`  in  1  sink accepts the byte when `valid && ready`.
- `io_tx_data`  out  8  ASCII byte.

## Operation
- States: IDLE, READ, WAIT, ADDR_AT, ADDR_HEX, ADDR_NL, DATA_HEX, DATA_NL, NEXT, DONE.
- IDLE: `io_start` -> READ with addr = 0, `last_valid` = 0.
- READ: `io_rd_en` = 1, `io_rd_addr` = addr -> WAIT.
- WAIT: capture `io_rd_data` into the word register.
  - Word == 0: go to NEXT (gap; sets `last_valid` = 0).
  - Word != 0 and (`last_valid` == 0 or addr != last_addr + 1): go to ADDR_AT.
  - Otherwise: go to DATA_HEX.
- ADDR_AT emits `@`. ADDR_HEX emits ceil(ADDR_W/4) lowercase hex digits of addr, MSB first (two digits for the default). ADDR_NL emits `\n` (0x0a).
- DATA_HEX emits DATA_W/4 lowercase hex digits of the word, MSB first, with leading zeros. DATA_NL emits `\n`, then sets last_addr = addr and `last_valid` = 1.
- NEXT: if addr == DEPTH-1, go to DONE; else increment addr and go to READ. No wrap to 0.
- DONE: `io_done` = 1 for one cycle, then IDLE.
- Nibble-to-ASCII mapping: 0–9 -> 0x30–0x39; a–f -> 0x61–0x66.
- `io_start` while not in IDLE is ignored.

## Timing
- Reset values: `io_busy`, `io_done`, `io_rd_en`, `io_tx_valid` are 0; `io_rd_addr` and `io_tx_data` are 0; state is IDLE.
- A reset asserted mid-dump aborts immediately with no partial-byte completion. Sink behaviour after the abort is the consumer's concern.
- Each emitting state holds `io_tx_valid` high and `io_tx_data` stable until accepted. Valid never drops and data never changes without acceptance.
- The state advances on the acceptance cycle. With `io_tx_ready` held high, one byte is emitted per cycle.
- `io_tx_valid` is high only in ADDR_AT, ADDR_HEX, ADDR_NL, DATA_HEX and DATA_NL.
- Zero word: 3 cycles (READ, WAIT, NEXT).
- Contiguous nonzero word: 3 + DATA_W/4 + 1 cycles with no backpressure.
- All-zero memory, start accepted at cycle 0: busy over cycles 1..3·DEPTH+1; `io_done` at cycle 3·DEPTH+1 (385 for the defaults).

## Structure
- Shared package `vhex_pkg` holds:
  - the state enum;
  - ASCII constants `CH_AT` = 0x40 and `CH_NL` = 0x0a;
  - function `nib2ascii`.
- The loader uses the same package.
- Sub-module `vhex_hex_serializer` (width parameter): load value plus digit count, shift out MSB nibble-first under the valid/ready handshake, and pulse `last` on the final digit. The writer instantiates it once and muxes it between address and data.
- Digit counter widths are $clog2(DATA_W/4) and $clog2(ceil(ADDR_W/4)).

## Test plan
- mem[0] = 5a5a0000, mem[1] = 5a5a0001, rest zero, ready = 1 -> stream `@00\n5a5a0000\n5a5a0001\n`, then one `io_done` pulse.
- mem[0x10] = 5a5a0010, mem[0x30] = 5a5a0030, rest zero -> `@10\n5a5a0010\n@30\n5a5a0030\n`.
- All-zero memory -> no tx bytes; `io_done` exactly 385 cycles after start; `io_start` pulses while busy are ignored.
- mem[0x7f] = 00000001 with random `io_tx_ready` (≈30% low) -> `@7f\n00000001\n`, byte-identical to the ready = 1 run; data is stable whenever valid && !ready; no wrap read of address 0.
- Reset pulsed during DATA_HEX of word 1 -> all outputs 0 the same cycle. A new start then yields the full stream from `@00`.
- Loopback: feed the writer output into the vhex loader -> the reloaded ROM equals the source memory word-for-word.
